// File: rtl/cpu_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module : cpu_ctrl_pkg
// Brief  : Shared run-control types and constants for the CPU pipeline sequencer
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HALT  = 2'd3
  } ctrl_state_e;

  localparam int          DEFAULT_DRAIN_CYCLES = 4;
  localparam logic [31:0] NOP_INSTR            = 32'h0000_0013;

endpackage

`default_nettype wire

// File: rtl/hazard_detect.sv
//------------------------------------------------------------------------------
// Module : hazard_detect
// Brief  : Combinational load-use and taken-branch detection for the ID stage
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hazard_detect #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              id_branch,
  input  logic              id_eq,
  output logic              load_use,
  output logic              taken
);

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign load_use = ex_memread && (ex_rd != '0) &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  assign taken    = id_branch && id_eq;

endmodule

`default_nettype wire

// File: rtl/pipeline_ctrl.sv
//------------------------------------------------------------------------------
// Module : pipeline_ctrl
// Brief  : Run-control FSM, hazard stall/flush generation and statistics counters
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pipeline_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int REG_AW       = 5,
  parameter int CNT_W        = 32,
  parameter int DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              ex_memread_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              id_branch_i,
  input  logic              id_eq_i,
  input  logic              if_halt_i,
  output logic              pipe_en_o,
  output logic              pc_write_o,
  output logic              pc_sel_o,
  output logic              ifid_write_o,
  output logic              ifid_flush_o,
  output logic              idex_nop_o,
  output logic [1:0]        state_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  cycle_cnt_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  localparam int              DW       = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ctrl_state_e      r_state;
  logic [DW-1:0]    r_drain_cnt;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             w_load_use;
  logic             w_taken;
  logic             w_active;

  hazard_detect #(
    .REG_AW (REG_AW)
  ) u_hazard_detect (
    .id_rs1     (id_rs1_i),
    .id_rs2     (id_rs2_i),
    .ex_memread (ex_memread_i),
    .ex_rd      (ex_rd_i),
    .id_branch  (id_branch_i),
    .id_eq      (id_eq_i),
    .load_use   (w_load_use),
    .taken      (w_taken)
  );

  assign w_active = (r_state == ST_RUN) || (r_state == ST_DRAIN);

  always_comb begin
    pipe_en_o    = 1'b0;
    pc_write_o   = 1'b0;
    pc_sel_o     = 1'b0;
    ifid_write_o = 1'b0;
    ifid_flush_o = 1'b0;
    idex_nop_o   = 1'b0;
    case (r_state)
      ST_RUN: begin
        pipe_en_o = 1'b1;
        if (w_load_use) begin
          idex_nop_o = 1'b1;
        end else begin
          pc_write_o   = 1'b1;
          ifid_write_o = 1'b1;
          pc_sel_o     = w_taken;
          ifid_flush_o = w_taken;
        end
      end
      ST_DRAIN: begin
        // Fetch is frozen; IF/ID keeps loading NOPs while older work retires.
        pipe_en_o    = 1'b1;
        ifid_write_o = 1'b1;
        ifid_flush_o = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= ST_IDLE;
      r_drain_cnt <= '0;
      r_cycle_cnt <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (start_i) r_state <= ST_RUN;
        ST_RUN: begin
          if (!w_load_use && !w_taken && if_halt_i) begin
            r_state     <= ST_DRAIN;
            r_drain_cnt <= DW'(DRAIN_CYCLES);
          end
        end
        ST_DRAIN: begin
          r_drain_cnt <= r_drain_cnt - DW'(1);
          if (r_drain_cnt == DW'(1)) r_state <= ST_HALT;
        end
        default: ;
      endcase

      if (w_active && (r_cycle_cnt != CNT_MAX))
        r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
      if ((r_state == ST_RUN) && w_load_use && (r_stall_cnt != CNT_MAX))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if ((r_state == ST_RUN) && !w_load_use && w_taken && (r_flush_cnt != CNT_MAX))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign state_o     = r_state;
  assign done_o      = (r_state == ST_HALT);
  assign cycle_cnt_o = r_cycle_cnt;
  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;

endmodule

`default_nettype wire
